// File: rtl/start_pulse_ctrl.sv
// Start-pulse controller: synchronise, debounce, gate and hold-off
// for the optical sync-pulse generator trigger button.
module start_pulse_ctrl #(
  parameter int DEB_CYCLES     = 1000000,
  parameter int PULSE_CYCLES   = 200000000,
  parameter int HOLDOFF_CYCLES = 50000000,
  parameter int CNT_W          = 32,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic        st_clk,
  input  logic        st_rst_n,
  input  logic        st_button,
  input  logic        st_en,
  input  logic        st_mode,
  input  logic        st_done,
  input  logic        st_abort,
  output logic        st_o,
  output logic        st_busy,
  output logic        st_fault,
  output logic [15:0] st_count
);

  localparam int DEB_L =
    (DEB_CYCLES > 0) ? DEB_CYCLES - 1 : 0;
  localparam int PULSE_L =
    (PULSE_CYCLES > 0) ? PULSE_CYCLES - 1 : 0;
  localparam int HOLD_L =
    (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_L);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_L);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_L);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HOLDOFF
  } state_t;

  logic             sync1;
  logic             sync2;
  logic             pressed_sync;
  logic             deb_lvl;
  logic             deb_prev;
  logic [CNT_W-1:0] deb_cnt;
  logic             press_evt;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             mode_q;
  logic             mode_n;
  logic             o_n;
  logic             busy_n;
  logic             fault_n;
  logic [15:0]      count_n;

  // Two-flop synchroniser for the raw button
  always_ff @(posedge st_clk) begin
    if (!st_rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= st_button;
      sync2 <= sync1;
    end
  end

  assign pressed_sync =
    (BTN_ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // Debounce; level starts pressed so a held button needs a release first
  always_ff @(posedge st_clk) begin
    if (!st_rst_n) begin
      deb_lvl  <= 1'b1;
      deb_prev <= 1'b1;
      deb_cnt  <= '0;
    end else begin
      deb_prev <= deb_lvl;
      if (pressed_sync != deb_lvl) begin
        if (deb_cnt == DEB_LAST) begin
          deb_lvl <= pressed_sync;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + ONE;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign press_evt = deb_lvl & ~deb_prev;

  // State and registered outputs
  always_ff @(posedge st_clk) begin
    if (!st_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      mode_q   <= 1'b0;
      st_o     <= 1'b0;
      st_busy  <= 1'b0;
      st_fault <= 1'b0;
      st_count <= 16'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      mode_q   <= mode_n;
      st_o     <= o_n;
      st_busy  <= busy_n;
      st_fault <= fault_n;
      st_count <= count_n;
    end
  end

  // Next state; abort beats done, done beats timeout
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mode_n  = mode_q;
    o_n     = st_o;
    busy_n  = st_busy;
    fault_n = st_fault;
    count_n = st_count;
    unique case (state)
      IDLE: begin
        o_n    = 1'b0;
        busy_n = 1'b0;
        if (press_evt && st_en) begin
          state_n = ACTIVE;
          o_n     = 1'b1;
          busy_n  = 1'b1;
          count_n = st_count + 16'd1;
          fault_n = 1'b0;
          mode_n  = st_mode;
          cnt_n   = '0;
        end
      end
      ACTIVE: begin
        o_n    = 1'b1;
        busy_n = 1'b1;
        cnt_n  = cnt + ONE;
        if (st_abort || (mode_q && st_done)) begin
          state_n = HOLDOFF;
          o_n     = 1'b0;
          cnt_n   = '0;
        end else if (cnt == PULSE_LAST) begin
          state_n = HOLDOFF;
          o_n     = 1'b0;
          cnt_n   = '0;
          if (mode_q) fault_n = 1'b1;
        end
      end
      HOLDOFF: begin
        o_n    = 1'b0;
        busy_n = 1'b1;
        cnt_n  = cnt + ONE;
        if (cnt == HOLD_LAST) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        o_n     = 1'b0;
        busy_n  = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

endmodule
